// File: rtl/lsu_mem_ctrl_if.sv
// lsu_mem_ctrl_if: CPU request/response handshake plus the word-addressed data_mem port.
interface lsu_mem_ctrl_if #(parameter int ADDR_W = 11);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wdata
    );
    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: serialized load/store initiator for data_mem; sub-word stores use read-modify-write
// and load results are lane-aligned and sign/zero-extended.
module lsu_mem_ctrl #(
    parameter int ADDR_W = 11
) (
    input logic           clk,
    input logic           rst,
    lsu_mem_ctrl_if.slave bus_if
);
    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_e;
    state_e            state_q, state_d;
    logic              we_q, uns_q, err_q;
    logic [1:0]        size_q, lane_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [31:0]       wdata_q, word_q;
    logic              acc, bad;
    logic [4:0]        sh;
    logic [31:0]       lane_w, ld, mask, merged;
    assign acc = bus_if.req_valid && state_q == IDLE;
    assign bad = bus_if.req_size == 2'b11
              || (bus_if.req_size == 2'b01 && bus_if.req_addr[0])
              || (bus_if.req_size == 2'b10 && bus_if.req_addr[1:0] != 2'b00)
              || (bus_if.req_addr >> (ADDR_W + 2)) != 32'd0;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= 2'b00;
            lane_q  <= 2'b00;
            waddr_q <= '0;
            wdata_q <= 32'd0;
            word_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            if (acc) begin
                we_q    <= bus_if.req_we;
                uns_q   <= bus_if.req_unsigned;
                err_q   <= bad;
                size_q  <= bus_if.req_size;
                lane_q  <= bus_if.req_addr[1:0];
                waddr_q <= bus_if.req_addr[ADDR_W+1:2];
                wdata_q <= bus_if.req_wdata;
            end
            if (state_q == RD) word_q <= bus_if.mem_rdata;
        end
    end
    // Word stores skip RD: nothing of the old word survives the write.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = !acc ? IDLE
                             : bad ? RESP
                             : (bus_if.req_we && bus_if.req_size == 2'b10) ? WR : RD;
            RD:      state_d = we_q ? WR : RESP;
            WR:      state_d = RESP;
            default: state_d = bus_if.resp_ready ? IDLE : RESP;
        endcase
    end
    always_comb begin
        sh     = {lane_q, 3'b000};
        lane_w = word_q >> sh;
        ld     = size_q == 2'b00 ? {{24{~uns_q & lane_w[7]}}, lane_w[7:0]}
               : size_q == 2'b01 ? {{16{~uns_q & lane_w[15]}}, lane_w[15:0]}
               : word_q;
        mask   = (size_q == 2'b00 ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
        merged = size_q == 2'b10 ? wdata_q : (word_q & ~mask) | ((wdata_q << sh) & mask);
        bus_if.req_ready  = state_q == IDLE;
        bus_if.resp_valid = state_q == RESP;
        bus_if.resp_err   = state_q == RESP && err_q;
        bus_if.resp_rdata = (state_q == RESP && !err_q && !we_q) ? ld : 32'd0;
        bus_if.mem_we     = state_q == WR;
        bus_if.mem_addr   = (state_q == RD || state_q == WR) ? waddr_q : '0;
        bus_if.mem_wdata  = state_q == WR ? merged : 32'd0;
    end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: directed requests against a behavioural data_mem, checked by a queue-based scoreboard.
module tb_lsu_mem_ctrl;
    localparam int ADDR_W = 11;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    lsu_mem_ctrl_if #(.ADDR_W(ADDR_W)) bus_if ();
    lsu_mem_ctrl #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus_if(bus_if));
    logic [31:0] mem [0:(1<<ADDR_W)-1];
    assign bus_if.mem_rdata = mem[bus_if.mem_addr];
    always @(posedge clk) if (bus_if.mem_we) mem[bus_if.mem_addr] <= bus_if.mem_wdata;
    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          lat;
    } exp_t;
    exp_t        sb_q[$];
    int          checks = 0;
    int          failures = 0;
    int          wcnt = 0;
    logic [31:0] w_addr = 0;
    logic [31:0] w_data = 0;
    int          cyc = 0;
    bit          infl = 0;
    bit          seen = 0;
    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask
    always @(negedge clk) begin
        exp_t e;
        if (infl) cyc++;
        if (infl && !seen && bus_if.resp_valid) begin
            seen = 1;
            if (sb_q.size() > 0) chk("latency", cyc, sb_q[0].lat);
        end
        if (bus_if.resp_valid && bus_if.resp_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_resp: got response with empty scoreboard");
            end else begin
                e = sb_q.pop_front();
                chk("resp_rdata", bus_if.resp_rdata, e.rd);
                chk("resp_err", {31'd0, bus_if.resp_err}, {31'd0, e.err});
            end
            infl = 0;
        end
        if (bus_if.req_valid && bus_if.req_ready) begin
            infl = 1;
            cyc = 0;
            seen = 0;
        end
        if (bus_if.mem_we) begin
            wcnt++;
            w_addr = {21'd0, bus_if.mem_addr};
            w_data = bus_if.mem_wdata;
        end
    end
    task automatic issue(logic we, logic [1:0] sz, logic uns, logic [31:0] addr, logic [31:0] wd);
        bus_if.req_valid    = 1'b1;
        bus_if.req_we       = we;
        bus_if.req_size     = sz;
        bus_if.req_unsigned = uns;
        bus_if.req_addr     = addr;
        bus_if.req_wdata    = wd;
    endtask
    task automatic do_req(string nm, logic we, logic [1:0] sz, logic uns, logic [31:0] addr,
                          logic [31:0] wd, logic [31:0] exp_rd, logic exp_err, int lat,
                          int expw, logic [31:0] exp_wd, int hold);
        int  w0;
        bit  ok;
        w0 = wcnt;
        @(posedge clk);
        #1;
        if (hold > 0) bus_if.resp_ready = 1'b0;
        sb_q.push_back('{exp_rd, exp_err, lat});
        issue(we, sz, uns, addr, wd);
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = bus_if.req_ready;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL %s_accept: req_ready stuck at 0, expected 1", nm);
        end
        @(posedge clk);
        #1;
        bus_if.req_valid = 1'b0;
        bus_if.req_addr  = 32'hFFFF_FFFF;
        bus_if.req_wdata = 32'hA5A5_A5A5;
        if (hold > 0) begin
            ok = 0;
            for (int i = 0; i < 10 && !ok; i++) begin
                @(negedge clk);
                ok = bus_if.resp_valid;
            end
            chk({nm, "_valid"}, {31'd0, ok}, 32'd1);
            for (int i = 0; i < hold; i++) begin
                chk({nm, "_hold_valid"}, {31'd0, bus_if.resp_valid}, 32'd1);
                chk({nm, "_hold_rdata"}, bus_if.resp_rdata, exp_rd);
                chk({nm, "_hold_ready"}, {31'd0, bus_if.req_ready}, 32'd0);
                @(negedge clk);
            end
            @(posedge clk);
            #1;
            bus_if.resp_ready = 1'b1;
        end
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = sb_q.size() == 0;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL %s_resp: no response within bound, expected one", nm);
            sb_q.delete();
        end
        @(posedge clk);
        #1;
        chk({nm, "_wcount"}, wcnt - w0, expw);
        if (expw > 0) begin
            chk({nm, "_waddr"}, w_addr, 32'd1);
            chk({nm, "_wdata"}, w_data, exp_wd);
        end
    endtask
    initial begin
        int w0;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'd0;
        bus_if.req_valid    = 1'b0;
        bus_if.req_we       = 1'b0;
        bus_if.req_size     = 2'b00;
        bus_if.req_unsigned = 1'b0;
        bus_if.req_addr     = 32'd0;
        bus_if.req_wdata    = 32'd0;
        bus_if.resp_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", {31'd0, bus_if.req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, bus_if.resp_valid}, 32'd0);
        chk("rst_resp_err", {31'd0, bus_if.resp_err}, 32'd0);
        chk("rst_resp_rdata", bus_if.resp_rdata, 32'd0);
        chk("rst_mem_we", {31'd0, bus_if.mem_we}, 32'd0);
        chk("rst_mem_addr", {21'd0, bus_if.mem_addr}, 32'd0);
        chk("rst_mem_wdata", bus_if.mem_wdata, 32'd0);
        //      name   we    size   uns   addr        wdata          rdata          err   lat w  wdata_exp     hold
        do_req("sw",   1, 2'b10, 0, 32'h004, 32'hDEADBEEF, 32'h0,         0,    2,  1, 32'hDEADBEEF, 0);
        do_req("lw",   0, 2'b10, 0, 32'h004, 32'h0,        32'hDEADBEEF,  0,    2,  0, 32'h0,        0);
        do_req("sb",   1, 2'b00, 0, 32'h005, 32'h80,       32'h0,         0,    3,  1, 32'hDEAD80EF, 0);
        do_req("lb",   0, 2'b00, 0, 32'h005, 32'h0,        32'hFFFFFF80,  0,    2,  0, 32'h0,        0);
        do_req("lbu",  0, 2'b00, 1, 32'h005, 32'h0,        32'h00000080,  0,    2,  0, 32'h0,        0);
        do_req("sh",   1, 2'b01, 0, 32'h006, 32'h1234,     32'h0,         0,    3,  1, 32'h123480EF, 0);
        do_req("lh",   0, 2'b01, 0, 32'h006, 32'h0,        32'h00001234,  0,    2,  0, 32'h0,        0);
        do_req("lhu",  0, 2'b01, 1, 32'h004, 32'h0,        32'h000080EF,  0,    2,  0, 32'h0,        0);
        do_req("lb7",  0, 2'b00, 0, 32'h007, 32'h0,        32'h00000012,  0,    2,  0, 32'h0,        0);
        do_req("lw2",  0, 2'b10, 0, 32'h004, 32'h0,        32'h123480EF,  0,    2,  0, 32'h0,        0);
        do_req("e_lh", 0, 2'b01, 0, 32'h007, 32'h0,        32'h0,         1,    1,  0, 32'h0,        0);
        do_req("e_sw", 1, 2'b10, 0, 32'h002, 32'h1,        32'h0,         1,    1,  0, 32'h0,        0);
        do_req("e_hi", 0, 2'b10, 0, 32'h2000, 32'h0,       32'h0,         1,    1,  0, 32'h0,        0);
        do_req("e_sz", 0, 2'b11, 0, 32'h004, 32'h0,        32'h0,         1,    1,  0, 32'h0,        0);
        do_req("bp",   0, 2'b10, 0, 32'h004, 32'h0,        32'h123480EF,  0,    2,  0, 32'h0,        5);
        chk("mem_after_err", mem[1], 32'h123480EF);
        // Reset lands on the RD cycle of a byte store: the write must never happen.
        w0 = wcnt;
        @(posedge clk);
        #1;
        issue(1'b1, 2'b00, 1'b0, 32'h004, 32'h55);
        @(negedge clk);
        chk("mid_accept_ready", {31'd0, bus_if.req_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus_if.req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_in_rd_addr", {21'd0, bus_if.mem_addr}, 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_req_ready", {31'd0, bus_if.req_ready}, 32'd1);
        chk("mid_resp_valid", {31'd0, bus_if.resp_valid}, 32'd0);
        repeat (3) @(negedge clk);
        chk("mid_wcount", wcnt - w0, 32'd0);
        chk("mid_mem", mem[1], 32'h123480EF);
        infl = 0;
        do_req("lw3",  0, 2'b10, 0, 32'h004, 32'h0,        32'h123480EF,  0,    2,  0, 32'h0,        0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
